// File: rtl/hyp_cordic_seq.sv
// Iterative hyperbolic CORDIC sequencer in rotation mode: returns cosh/sinh of a signed Q4.12 angle.
// Optional input range check is compiled in when HYP_CORDIC_RANGE_CHECK_EN is defined.
module hyp_cordic_seq #(
   parameter int DWIDTH = 16,
   parameter int FRAC   = DWIDTH - 4,
   parameter int NITER  = 14,
   parameter int X0     = 4946,
   parameter int ZMAX   = 4579
) (
   input  logic              iClk,
   input  logic              iRstN,
   input  logic              iValid,
   output logic              oReady,
   input  logic [DWIDTH-1:0] iAngle,
   output logic              oValid,
   input  logic              iReady,
   output logic [DWIDTH-1:0] oCosh,
   output logic [DWIDTH-1:0] oSinh,
   output logic              oErr,
   output logic              oSign,
   output logic [4:0]        oShift,
   output logic              oComp
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_RANGE, S_DONE} state_t;

   state_t state, state_nxt;

   logic signed [DWIDTH-1:0] x, y, z;
   logic [4:0]               idx;
   logic                     rep;
   logic                     out_valid;
   logic [DWIDTH-1:0]        cosh_q, sinh_q;
   logic                     err;

   logic                     accept, oor, dir, is_repeat, last_iter;
   logic signed [DWIDTH-1:0] dx, dy, atanh_cur;
   logic signed [DWIDTH-1:0] atanh_rom [0:31];

   // atanh(2^-i) from its odd power series at 60 fractional bits, rounded to FRAC bits.
   function automatic logic [DWIDTH-1:0] atanh_q(input int unsigned i);
      logic [63:0] acc;
      int unsigned e;
      acc = '0;
      for (int unsigned k = 0; k < 32; k++) begin
         e = (2 * k + 1) * i;
         if (e <= 60)
            acc = acc + ((64'd1 << (60 - e)) / 64'(2 * k + 1));
      end
      acc = (acc + (64'd1 << (59 - FRAC))) >> (60 - FRAC);
      return acc[DWIDTH-1:0];
   endfunction

   for (genvar g = 0; g < 32; g++) begin : g_rom
      if (g >= 1 && g <= NITER) begin : g_on
         assign atanh_rom[g] = atanh_q(g);
      end else begin : g_off
         assign atanh_rom[g] = '0;
      end
   end

   assign accept = iValid && (state == S_IDLE);

`ifdef HYP_CORDIC_RANGE_CHECK_EN
   localparam logic signed [DWIDTH-1:0] ZMAX_S = DWIDTH'(ZMAX);
   assign oor = ($signed(iAngle) > ZMAX_S) || ($signed(iAngle) < -ZMAX_S);
`else
   assign oor = 1'b0;
`endif

   assign dir       = z[DWIDTH-1];
   assign is_repeat = ((idx == 5'd4) || (idx == 5'd13)) && !rep;
   assign last_iter = (idx == 5'(NITER)) && !is_repeat;
   assign dx        = y >>> idx;
   assign dy        = x >>> idx;
   assign atanh_cur = atanh_rom[idx];

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = oor ? S_RANGE : S_RUN;
         S_RUN:   if (last_iter) state_nxt = S_DONE;
         S_RANGE: state_nxt = S_DONE;
         S_DONE:  if (out_valid && iReady) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         x         <= '0;
         y         <= '0;
         z         <= '0;
         idx       <= '0;
         rep       <= 1'b0;
         out_valid <= 1'b0;
         cosh_q    <= '0;
         sinh_q    <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  // a rejected angle runs nothing, so zeroing x here yields the 0/0 result
                  x   <= oor ? '0 : DWIDTH'(X0);
                  y   <= '0;
                  z   <= iAngle;
                  idx <= 5'd1;
                  rep <= 1'b0;
                  err <= oor;
               end
            end
            S_RUN: begin
               if (!dir) begin
                  x <= x + dx;
                  y <= y + dy;
                  z <= z - atanh_cur;
               end else begin
                  x <= x - dx;
                  y <= y - dy;
                  z <= z + atanh_cur;
               end
               if (is_repeat) begin
                  rep <= 1'b1;
               end else begin
                  rep <= 1'b0;
                  idx <= idx + 5'd1;
               end
            end
            S_DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  cosh_q    <= x;
                  sinh_q    <= y;
               end else if (iReady) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign oReady = (state == S_IDLE);
   assign oValid = out_valid;
   assign oCosh  = cosh_q;
   assign oSinh  = sinh_q;
   assign oErr   = err;
   assign oComp  = (state != S_RUN);
   assign oSign  = (state == S_RUN) && dir;
   assign oShift = (state == S_RUN) ? idx : '0;

endmodule
